// File: rtl/lelo_temp_pkg.sv
// ---------------------------------------------------------------------------
// lelo_temp_pkg
// Shared types and constants for the LELO ring-oscillator temperature readout.
//   state_t     : measurement FSM states
//   WIN_LOG2_W  : width of the window-size exponent input
//   ch_sel_w()  : width of a channel-select bus for a given channel count
// ---------------------------------------------------------------------------
package lelo_temp_pkg;

  localparam int WIN_LOG2_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    LATCH   = 2'd3
  } state_t;

  // A single-channel build still needs a one-bit select port.
  function automatic int ch_sel_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/lelo_edge_counter.sv
// ---------------------------------------------------------------------------
// lelo_edge_counter
// One oscillator channel: synchroniser, rising-edge detector and a saturating
// edge counter.
//   clk, rst : system clock, synchronous active-high reset
//   osc      : asynchronous oscillator output
//   clr      : clears the counter and its overflow flag
//   en       : counts a detected edge this cycle; edges seen while low are lost
//   cnt      : edge count, sticks at all-ones
//   ovf      : set once the count has reached all-ones
// ---------------------------------------------------------------------------
module lelo_edge_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  // The synchroniser runs every cycle, independent of en, so the detector
  // always sees a settled level when counting resumes.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Saturating count: the flag rises on the edge that reaches all-ones, and
  // the count never wraps past it.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (en && rise) begin
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      if (cnt >= CNT_MAX - CNT_W'(1)) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/lelo_temp_readout.sv
// ---------------------------------------------------------------------------
// lelo_temp_readout
// Multi-channel frequency readout for leakage-based ring-oscillator
// temperature sensors. Counts oscillator edges over a 2^k-clock gate window,
// latches per-channel saturating results and muxes one onto an 8-bit bus.
//   clk, rst  : system clock, synchronous active-high reset
//   ena       : clock enable for FSM, window counter and edge counters
//   osc_in    : asynchronous oscillator outputs, one per channel
//   start     : level, begins a measurement when sampled in IDLE
//   cont      : re-arm automatically after each window
//   win_log2  : window exponent, clamped to WIN_MAX, sampled in ARM
//   ch_sel    : channel shown on result / ovf / data_out
//   byte_sel  : 0 = result[7:0], 1 = result[15:8] on data_out
//   busy      : high in ARM, MEASURE and LATCH
//   done      : one-cycle pulse in LATCH
//   ovf       : saturation flag of the selected channel's last result
//   result    : last latched count of the selected channel
//   data_out  : selected byte of result
// ---------------------------------------------------------------------------
module lelo_temp_readout
  import lelo_temp_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int WIN_MAX     = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  input  logic [N_CH-1:0]             osc_in,
  input  logic                        start,
  input  logic                        cont,
  input  logic [WIN_LOG2_W-1:0]       win_log2,
  input  logic [ch_sel_w(N_CH)-1:0]   ch_sel,
  input  logic                        byte_sel,
  output logic                        busy,
  output logic                        done,
  output logic                        ovf,
  output logic [CNT_W-1:0]            result,
  output logic [7:0]                  data_out
);

  localparam int WIN_W = WIN_MAX + 1;

  state_t                  state;
  logic [WIN_W-1:0]        win;
  logic [WIN_LOG2_W-1:0]   win_k;
  logic                    cnt_clr;
  logic                    cnt_en;
  logic [CNT_W-1:0]        cnt     [N_CH];
  logic [N_CH-1:0]         ovf_run;
  logic [CNT_W-1:0]        res_q   [N_CH];
  logic [N_CH-1:0]         res_ovf_q;
  logic [15:0]             res16;

  assign win_k   = (win_log2 > WIN_LOG2_W'(WIN_MAX)) ? WIN_LOG2_W'(WIN_MAX) : win_log2;
  assign cnt_clr = ena && (state == ARM);
  assign cnt_en  = ena && (state == MEASURE);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    lelo_edge_counter #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_cnt (
      .clk (clk),
      .rst (rst),
      .osc (osc_in[i]),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (cnt[i]),
      .ovf (ovf_run[i])
    );
  end

  // Measurement FSM. win holds the remaining MEASURE cycles minus one, so a
  // window of 2^k cycles ends on the cycle that sees win == 0. done is cleared
  // whenever ena is low so a frozen LATCH never stretches the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      win   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (!ena) begin
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          win   <= (WIN_W'(1) << win_k) - WIN_W'(1);
          state <= MEASURE;
        end
        MEASURE: begin
          if (win == '0) begin
            state <= LATCH;
            done  <= 1'b1;
          end else begin
            win <= win - WIN_W'(1);
          end
        end
        LATCH: begin
          state <= cont ? ARM : IDLE;
          busy  <= cont;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result register file.
  // NOTE: the result array is reset explicitly because a reset must wipe
  // previous windows; arrays without that need are better left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) res_q[i] <= '0;
      res_ovf_q <= '0;
    end else if (ena && (state == LATCH)) begin
      for (int i = 0; i < N_CH; i++) res_q[i] <= cnt[i];
      res_ovf_q <= ovf_run;
    end
  end

  // Output select; an out-of-range channel reads as zero.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    if (int'(ch_sel) < N_CH) begin
      result = res_q[ch_sel];
      ovf    = res_ovf_q[ch_sel];
    end
  end

  if (CNT_W >= 16) begin : g_wide
    assign res16 = result[15:0];
  end else begin : g_narrow
    assign res16 = {{(16 - CNT_W){1'b0}}, result};
  end

  assign data_out = byte_sel ? res16[15:8] : res16[7:0];

endmodule

// File: tb/tb_lelo_temp_readout.sv
// ---------------------------------------------------------------------------
// tb_lelo_temp_readout
// Two instances: dut_a (3 channels, 16-bit counts, WIN_MAX 20) and dut_b
// (2 channels, 8-bit counts, WIN_MAX 10). Oscillators are square waves with
// randomised periods; every rising edge is logged with the clock index at
// which it is first sampled. The expected count of a window is the number of
// logged edges whose sampled index plus the synchroniser latency falls inside
// that window's enabled counting cycles, saturated at the counter maximum.
// ---------------------------------------------------------------------------
module tb_lelo_temp_readout;
  import lelo_temp_pkg::*;

  localparam int S  = 2;   // synchroniser depth used by both instances
  localparam int NA = 3;
  localparam int NB = 2;

  logic clk = 1'b0;
  logic rst, ena;

  logic [NA-1:0] osc_a;
  logic          start_a, cont_a, bsel_a;
  logic [4:0]    wl_a;
  logic [1:0]    sel_a;
  logic          busy_a, done_a, ovf_a;
  logic [15:0]   res_a;
  logic [7:0]    dout_a;

  logic [NB-1:0] osc_b;
  logic          start_b, cont_b, bsel_b;
  logic [4:0]    wl_b;
  logic [0:0]    sel_b;
  logic          busy_b, done_b, ovf_b;
  logic [7:0]    res_b;
  logic [7:0]    dout_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int per [5];
  int pos [5];
  bit run [5];
  bit lvl [5];
  int rise_q [5][$];

  always #5 clk = ~clk;

  lelo_temp_readout #(.N_CH(NA), .CNT_W(16), .WIN_MAX(20), .SYNC_STAGES(S)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .osc_in(osc_a), .start(start_a), .cont(cont_a),
    .win_log2(wl_a), .ch_sel(sel_a), .byte_sel(bsel_a), .busy(busy_a), .done(done_a),
    .ovf(ovf_a), .result(res_a), .data_out(dout_a)
  );

  lelo_temp_readout #(.N_CH(NB), .CNT_W(8), .WIN_MAX(10), .SYNC_STAGES(S)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .osc_in(osc_b), .start(start_b), .cont(cont_b),
    .win_log2(wl_b), .ch_sel(sel_b), .byte_sel(bsel_b), .busy(busy_b), .done(done_b),
    .ovf(ovf_b), .result(res_b), .data_out(dout_b)
  );

  initial forever @(posedge clk) cyc++;

  // Oscillator driver: updates on the falling edge, so a new level is first
  // sampled at clock index cyc+1.
  initial begin
    bit nl;
    osc_a = '0;
    osc_b = '0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
        nl = 1'b0;
        if (run[c]) begin
          pos[c]++;
          nl = (pos[c] % per[c]) < (per[c] / 2);
        end
        if (nl && !lvl[c]) rise_q[c].push_back(cyc + 1);
        lvl[c] = nl;
      end
      osc_a = {lvl[2], lvl[1], lvl[0]};
      osc_b = {lvl[4], lvl[3]};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int count_rises(input int ch, input int lo, input int hi);
    int n = 0;
    for (int i = 0; i < rise_q[ch].size(); i++)
      if (rise_q[ch][i] >= lo && rise_q[ch][i] <= hi) n++;
    return n;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Start pulse; t is the clock index at which start is sampled.
  task automatic pulse_start(input bit b, output int t);
    @(negedge clk);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    t = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Returns the clock index after which done was seen high, or -1 on timeout.
  task automatic wait_done(input bit b, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((b ? done_b : done_a) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Window started at t with len enabled MEASURE cycles.
  task automatic check_win(input bit b, input string tag, input int t, input int len);
    int n, lim, e, eo, nch;
    lim = b ? 255 : 65535;
    nch = b ? NB : NA;
    for (int ch = 0; ch < nch; ch++) begin
      n  = count_rises(b ? NA + ch : ch, t + 2 - S, t + 1 + len - S);
      e  = (n > lim) ? lim : n;
      eo = (n >= lim) ? 1 : 0;
      @(negedge clk);
      if (b) begin
        sel_b = 1'(ch); bsel_b = 1'b0; #1;
        check($sformatf("%s_ch%0d_res", tag, ch), 32'(res_b), e);
        check($sformatf("%s_ch%0d_ovf", tag, ch), 32'(ovf_b), eo);
        check($sformatf("%s_ch%0d_lo", tag, ch), 32'(dout_b), 32'(e[7:0]));
        bsel_b = 1'b1; #1;
        check($sformatf("%s_ch%0d_hi", tag, ch), 32'(dout_b), 32'(e[15:8]));
      end else begin
        sel_a = 2'(ch); bsel_a = 1'b0; #1;
        check($sformatf("%s_ch%0d_res", tag, ch), 32'(res_a), e);
        check($sformatf("%s_ch%0d_ovf", tag, ch), 32'(ovf_a), eo);
        check($sformatf("%s_ch%0d_lo", tag, ch), 32'(dout_a), 32'(e[7:0]));
        bsel_a = 1'b1; #1;
        check($sformatf("%s_ch%0d_hi", tag, ch), 32'(dout_a), 32'(e[15:8]));
      end
    end
  endtask

  initial begin
    int t, t0, t2, t3, at, a;

    rst = 1'b1; ena = 1'b1;
    start_a = 1'b0; cont_a = 1'b0; wl_a = 5'd0; sel_a = '0; bsel_a = 1'b0;
    start_b = 1'b0; cont_b = 1'b0; wl_b = 5'd0; sel_b = '0; bsel_b = 1'b0;
    per[0] = 8;
    per[1] = 16;
    per[2] = int'($urandom_range(2, 20));
    per[3] = 4;
    per[4] = int'($urandom_range(6, 20));
    for (int c = 0; c < 5; c++) begin
      pos[c] = int'($urandom_range(0, 15));
      run[c] = 1'b1;
      lvl[c] = 1'b0;
    end

    // Reset held for three cycles with the oscillators toggling.
    repeat (3) @(negedge clk);
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_done_a", 32'(done_a), 0);
    check("rst_busy_b", 32'(busy_b), 0);
    check("rst_done_b", 32'(done_b), 0);
    for (int i = 0; i < 4; i++) begin
      sel_a = 2'(i); #1;
      check($sformatf("rst_res_a%0d", i), 32'(res_a), 0);
      check($sformatf("rst_ovf_a%0d", i), 32'(ovf_a), 0);
    end
    for (int i = 0; i < 2; i++) begin
      sel_b = 1'(i); #1;
      check($sformatf("rst_res_b%0d", i), 32'(res_b), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single shot, 256-cycle window; a late win_log2 change must not matter.
    wl_a = 5'd8;
    pulse_start(1'b0, t);
    wait_until(t + 5);
    wl_a = 5'd0;
    wait_done(1'b0, 400, at);
    check("t2_done_time", at, t + 1 + 256);
    @(negedge clk);
    check("t2_idle_busy", 32'(busy_a), 0);
    check("t2_done_low", 32'(done_a), 0);
    check_win(1'b0, "t2", t, 256);
    @(negedge clk);
    sel_a = 2'd3; bsel_a = 1'b0; #1;
    check("t2_oor_res", 32'(res_a), 0);
    check("t2_oor_dout", 32'(dout_a), 0);

    // Saturation on the 8-bit instance; win_log2 = 31 clamps to 10.
    wl_b = 5'd31;
    pulse_start(1'b1, t);
    wait_done(1'b1, 1200, at);
    check("t3_done_time", at, t + 1 + 1024);
    check_win(1'b1, "t3", t, 1024);

    // Continuous mode with a 16-cycle window, then cont drops mid-window.
    for (int c = 0; c < NA; c++) per[c] = int'($urandom_range(2, 12));
    wl_a = 5'd4;
    cont_a = 1'b1;
    pulse_start(1'b0, t0);
    for (int j = 0; j < 3; j++) begin
      wait_done(1'b0, 40, at);
      check($sformatf("t4_done_time%0d", j), at, t0 + 18 * j + 17);
      check_win(1'b0, $sformatf("t4_w%0d", j), t0 + 18 * j, 16);
    end
    wait_until(t0 + 54 + 8);
    cont_a = 1'b0;
    wait_done(1'b0, 40, at);
    check("t4_last_done", at, t0 + 54 + 17);
    @(negedge clk);
    check("t4_idle_busy", 32'(busy_a), 0);
    check_win(1'b0, "t4_w3", t0 + 54, 16);
    wait_done(1'b0, 40, at);
    check("t4_no_more_done", at, -1);

    // ena low for 50 cycles mid-window with the oscillators stopped.
    for (int c = 0; c < NA; c++) per[c] = int'($urandom_range(2, 10));
    wl_a = 5'd6;
    pulse_start(1'b0, t);
    wait_until(t + 20);
    for (int c = 0; c < NA; c++) run[c] = 1'b0;
    wait_until(t + 25);
    ena = 1'b0;
    a = cyc;
    wait_until(a + 25);
    check("t5_gap_busy", 32'(busy_a), 1);
    check("t5_gap_done", 32'(done_a), 0);
    wait_until(a + 50);
    ena = 1'b1;
    for (int c = 0; c < NA; c++) run[c] = 1'b1;
    wait_done(1'b0, 200, at);
    check("t5_done_time", at, t + 1 + 64 + 50);
    check_win(1'b0, "t5", t, 64 + 50);

    // A start pulse while busy adds no window.
    for (int c = 0; c < NA; c++) per[c] = int'($urandom_range(2, 20));
    wl_a = 5'd8;
    pulse_start(1'b0, t);
    wait_until(t + 50);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0, 400, at);
    check("t6_done_time", at, t + 1 + 256);
    wait_done(1'b0, 300, at);
    check("t6_no_rearm", at, -1);

    // Reset at MEASURE cycle 100 returns to the reset state.
    pulse_start(1'b0, t2);
    wait_until(t2 + 1 + 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_busy", 32'(busy_a), 0);
    check("t6_rst_done", 32'(done_a), 0);
    for (int i = 0; i < NA; i++) begin
      sel_a = 2'(i); #1;
      check($sformatf("t6_rst_res%0d", i), 32'(res_a), 0);
    end

    // Fresh measurement after the reset.
    wl_a = 5'd3;
    pulse_start(1'b0, t3);
    wait_done(1'b0, 40, at);
    check("t6_fresh_done", at, t3 + 1 + 8);
    check_win(1'b0, "t6_fresh", t3, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
